// File: rtl/aes_cmd_ctrl_if.sv
// Stream bundle for the AES command controller.
// The slave view is the controller; the master view is the command source/sink.
interface aes_cmd_ctrl_if #(
    parameter int WORD_S = 32
);
    logic [WORD_S-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [WORD_S-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        input  m_axis_tready,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast
    );

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tlast,
        output m_axis_tready,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast
    );
endinterface

// File: rtl/aes_cmd_ctrl.sv
// Command sequencer between a 32-bit stream pair and an iterative AES-128 core.
// Collects a key/block payload, fires the core, streams the 128-bit reply.
module aes_cmd_ctrl #(
    parameter int          WORD_S      = 32,
    parameter int          BLK_S       = 128,
    parameter int          KEY_S       = 128,
    parameter logic [31:0] CMD_SET_KEY = 32'h0000_0010,
    parameter logic [31:0] CMD_ENCRYPT = 32'h0000_0020
) (
    input  logic             clk,
    input  logic             reset,
    aes_cmd_ctrl_if.slave    axis,
    output logic [0:KEY_S-1] aes_key,
    output logic [0:BLK_S-1] aes_plaintext,
    output logic             aes_key_load,
    output logic             aes_en,
    input  logic             aes_done,
    input  logic [0:BLK_S-1] aes_ciphertext,
    output logic             cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_START,
        S_WAIT,
        S_TX
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             op_enc;
    logic [1:0]       cnt;
    logic [0:BLK_S-1] obuf;
    logic [6:0]       base;
    logic             s_fire;
    logic             m_fire;
    logic             is_key;
    logic             is_enc;
    logic             last_word;
    logic             unused_tlast;

    // Word n occupies bits [32n : 32n+31]; bit 0 is the MSB of word 0.
    assign base      = {cnt, 5'd0};
    assign is_key    = axis.s_axis_tdata == CMD_SET_KEY;
    assign is_enc    = axis.s_axis_tdata == CMD_ENCRYPT;
    assign last_word = cnt == 2'd3;

    assign axis.s_axis_tready = !reset
                              && (state == S_IDLE || state == S_RX);
    assign s_fire = axis.s_axis_tvalid && axis.s_axis_tready;

    assign axis.m_axis_tvalid = state == S_TX;
    assign axis.m_axis_tdata  = obuf[base +: WORD_S];
    assign axis.m_axis_tlast  = axis.m_axis_tvalid && last_word;
    assign m_fire = axis.m_axis_tvalid && axis.m_axis_tready;

    assign aes_key_load = state == S_START && !op_enc;
    assign aes_en       = state == S_START && op_enc;

    // Framing comes from the command, so tlast is not needed.
    assign unused_tlast = axis.s_axis_tlast;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (s_fire && (is_key || is_enc)) begin
                    state_nx = S_RX;
                end
            end
            S_RX: begin
                if (s_fire && last_word) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (aes_done) begin
                    state_nx = S_TX;
                end
            end
            S_TX: begin
                if (m_fire && last_word) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            op_enc        <= 1'b0;
            aes_key       <= '0;
            aes_plaintext <= '0;
            obuf          <= '0;
            cmd_err       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (s_fire) begin
                        cnt <= '0;
                        if (is_enc) begin
                            op_enc <= 1'b1;
                        end else if (is_key) begin
                            op_enc <= 1'b0;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                S_RX: begin
                    // Counter wraps to 0 on the 4th word, ready for TX.
                    if (s_fire) begin
                        cnt <= cnt + 2'd1;
                        if (op_enc) begin
                            aes_plaintext[base +: WORD_S] <= axis.s_axis_tdata;
                        end else begin
                            aes_key[base +: WORD_S] <= axis.s_axis_tdata;
                        end
                    end
                end
                S_WAIT: begin
                    if (aes_done) begin
                        obuf <= op_enc ? aes_ciphertext : '0;
                    end
                end
                S_TX: begin
                    if (m_fire) begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
